// File: rtl/tiny_cpu_core.sv
// tiny_cpu_core: 8-bit accumulator CPU with a byte-loaded 16x8 program store and four registers.
// Every instruction spends one FETCH and one EXEC cycle; HLT parks the core until start or rst.
module tiny_cpu_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    input  logic       start,
    input  logic [7:0] in_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       busy,
    output logic       halted,
    output logic [3:0] pc_dbg
);
    localparam int unsigned MEM_DEPTH = 16;
    localparam int unsigned NREGS     = 4;
    localparam int unsigned AW        = $clog2(MEM_DEPTH);
    localparam int unsigned RW        = $clog2(NREGS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADDI = 4'h2,
        OP_SUBI = 4'h3,
        OP_LDR  = 4'h4,
        OP_STR  = 4'h5,
        OP_ADD  = 4'h6,
        OP_IN   = 4'h7,
        OP_OUT  = 4'h8,
        OP_JMP  = 4'h9,
        OP_JZ   = 4'hA,
        OP_JC   = 4'hB,
        OP_HLT  = 4'hF
    } op_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] load_ptr_q, load_ptr_d;
    logic [7:0]    acc_q, acc_d;
    logic          carry_q, carry_d;
    logic [7:0]    ir_q, ir_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    regs_q [NREGS];
    logic [7:0]    regs_d [NREGS];
    logic [7:0]    mem_q  [MEM_DEPTH];

    logic          mem_we;
    op_e           op;
    logic [7:0]    imm;
    logic [RW-1:0] rsel;
    logic [8:0]    alu;

    assign op   = op_e'(ir_q[7:4]);
    assign imm  = {4'b0000, ir_q[3:0]};
    assign rsel = ir_q[RW-1:0];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        load_ptr_d  = load_ptr_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        ir_d        = ir_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        regs_d      = regs_q;
        mem_we      = 1'b0;
        alu         = '0;
        load_ready  = ((state_q == ST_IDLE) || (state_q == ST_HALT)) && !start;

        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                // start takes precedence, so a byte offered in the same cycle is dropped
                if (start) begin
                    pc_d       = '0;
                    acc_d      = '0;
                    carry_d    = 1'b0;
                    regs_d     = '{default: '0};
                    load_ptr_d = '0;
                    state_d    = ST_FETCH;
                end else if (load_valid) begin
                    mem_we     = 1'b1;
                    load_ptr_d = load_ptr_q + AW'(1);
                end
            end
            ST_FETCH: begin
                ir_d    = mem_q[pc_q];
                pc_d    = pc_q + AW'(1);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (op)
                    OP_LDI: acc_d = imm;
                    OP_ADDI: begin
                        alu              = {1'b0, acc_q} + {1'b0, imm};
                        {carry_d, acc_d} = alu;
                    end
                    OP_SUBI: begin
                        // bit 8 of the 9-bit difference is the borrow
                        alu              = {1'b0, acc_q} - {1'b0, imm};
                        {carry_d, acc_d} = alu;
                    end
                    OP_LDR: acc_d = regs_q[rsel];
                    OP_STR: regs_d[rsel] = acc_q;
                    OP_ADD: begin
                        alu              = {1'b0, acc_q} + {1'b0, regs_q[rsel]};
                        {carry_d, acc_d} = alu;
                    end
                    OP_IN: acc_d = in_data;
                    OP_OUT: begin
                        out_data_d  = acc_q;
                        out_valid_d = 1'b1;
                    end
                    OP_JMP: pc_d = ir_q[AW-1:0];
                    OP_JZ: begin
                        if (acc_q == '0) pc_d = ir_q[AW-1:0];
                    end
                    OP_JC: begin
                        if (carry_q) pc_d = ir_q[AW-1:0];
                    end
                    OP_HLT: state_d = ST_HALT;
                    default: ;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            load_ptr_q  <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            ir_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            regs_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            load_ptr_q  <= load_ptr_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            ir_q        <= ir_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            regs_q      <= regs_d;
        end
    end

    // Program store keeps its contents across rst; rst only blocks a pending write
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[load_ptr_q] <= load_data;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign halted    = (state_q == ST_HALT);
    assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_tiny_cpu_core.sv
// Self-checking bench for tiny_cpu_core: directed programs plus random programs, all compared
// per cycle against an instruction-level interpreter of the ISA.
module tb_tiny_cpu_core;
    localparam int MAXC = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       start = 1'b0;
    logic [7:0] in_data = '0;
    logic       load_ready, out_valid, busy, halted;
    logic [7:0] out_data;
    logic [3:0] pc_dbg;

    int n_checks = 0;
    int n_errors = 0;

    tiny_cpu_core dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .start      (start),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .halted     (halted),
        .pc_dbg     (pc_dbg)
    );

    always #5 clk = ~clk;

    // Reference: program image, load pointer, last OUT value, and the expected per-cycle outputs
    logic [7:0] m_mem [16];
    int         m_ptr = 0;
    logic [7:0] m_od  = '0;
    logic [3:0] e_pc   [MAXC];
    logic       e_busy [MAXC];
    logic       e_halt [MAXC];
    logic       e_ov   [MAXC];
    logic [7:0] e_od   [MAXC];
    int         trace_len;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void put(int c, int pc, bit bz, bit hl, bit ov, logic [7:0] od);
        e_pc[c]   = 4'(pc);
        e_busy[c] = bz;
        e_halt[c] = hl;
        e_ov[c]   = ov;
        e_od[c]   = od;
    endfunction

    // Index c = state observed after the c-th clock edge following the start edge
    function automatic void build_trace(input logic [7:0] in_val);
        int acc = 0, carry = 0, pc = 0, t, op, imm, idx, c = 0;
        int r[4] = '{0, 0, 0, 0};
        logic [7:0] od = m_od;
        logic [7:0] ir;
        bit done = 0, ov;
        put(0, 0, 1, 0, 0, od);
        while (!done && c + 2 < MAXC) begin
            ir  = m_mem[pc];
            pc  = (pc + 1) % 16;
            put(c + 1, pc, 1, 0, 0, od);
            op  = int'(ir[7:4]);
            imm = int'(ir[3:0]);
            idx = int'(ir[1:0]);
            ov  = 0;
            case (op)
                1:  acc = imm;
                2:  begin t = acc + imm;    carry = (t > 255) ? 1 : 0; acc = t % 256; end
                3:  begin t = acc - imm;    carry = (t < 0) ? 1 : 0;   acc = (t + 256) % 256; end
                4:  acc = r[idx];
                5:  r[idx] = acc;
                6:  begin t = acc + r[idx]; carry = (t > 255) ? 1 : 0; acc = t % 256; end
                7:  acc = int'(in_val);
                8:  begin od = 8'(acc); ov = 1; end
                9:  pc = imm;
                10: if (acc == 0) pc = imm;
                11: if (carry != 0) pc = imm;
                15: done = 1;
                default: ;
            endcase
            put(c + 2, pc, !done, done, ov, od);
            c += 2;
        end
        if (done) begin
            for (int k = c + 1; k < MAXC; k++) put(k, pc, 0, 1, 0, od);
            trace_len = MAXC;
        end else begin
            trace_len = c + 1;
        end
    endfunction

    task automatic do_reset;
        rst        = 1'b1;
        load_valid = 1'($urandom_range(0, 1));
        load_data  = 8'($urandom);
        tick;
        rst        = 1'b0;
        load_valid = 1'b0;
        m_ptr      = 0;
        m_od       = '0;
        #1;
        check_eq("rst_pc",    8'(pc_dbg),     8'd0);
        check_eq("rst_busy",  8'(busy),       8'd0);
        check_eq("rst_halt",  8'(halted),     8'd0);
        check_eq("rst_ov",    8'(out_valid),  8'd0);
        check_eq("rst_od",    out_data,       8'd0);
        check_eq("rst_ready", 8'(load_ready), 8'd1);
    endtask

    task automatic load_prog(input logic [7:0] b [32], input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    load_valid = 1'b0;
                    load_data  = 8'($urandom);
                    tick;
                end
            end
            load_valid = 1'b1;
            load_data  = b[i];
            #1;
            check_eq("ready_load", 8'(load_ready), 8'd1);
            tick;
            m_mem[m_ptr] = b[i];
            m_ptr        = (m_ptr + 1) % 16;
            load_valid   = 1'b0;
        end
    endtask

    task automatic run_prog(input int n, input bit with_load, input bit noise, output bit ended_halt);
        int len;
        build_trace(in_data);
        start      = 1'b1;
        load_valid = with_load;
        load_data  = 8'h80;
        #1;
        check_eq("ready_start", 8'(load_ready), 8'd0);
        tick;
        start      = 1'b0;
        load_valid = 1'b0;
        m_ptr      = 0;
        len = (n < trace_len) ? n : trace_len;
        for (int c = 0; c < len; c++) begin
            check_eq("pc",        8'(pc_dbg),    8'(e_pc[c]));
            check_eq("busy",      8'(busy),      8'(e_busy[c]));
            check_eq("halted",    8'(halted),    8'(e_halt[c]));
            check_eq("out_valid", 8'(out_valid), 8'(e_ov[c]));
            check_eq("out_data",  out_data,      e_od[c]);
            if (c < len - 1) begin
                if (noise && e_busy[c]) begin
                    load_valid = 1'($urandom_range(0, 1));
                    load_data  = 8'($urandom);
                    start      = ($urandom_range(0, 3) == 0);
                    #1;
                    check_eq("ready_busy", 8'(load_ready), 8'd0);
                end
                tick;
                start      = 1'b0;
                load_valid = 1'b0;
            end
        end
        m_od       = e_od[len - 1];
        ended_halt = e_halt[len - 1];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pg [32];
        bit h;

        do_reset;
        pg = '{default: '0};
        load_prog(pg, 16, 0);

        // LDI 5; OUT; HLT
        pg[0] = 8'h15; pg[1] = 8'h80; pg[2] = 8'hF0;
        load_prog(pg, 3, 1);
        run_prog(20, 0, 0, h);
        check_eq("basic_halted", 8'(halted), 8'd1);
        check_eq("basic_out",    out_data,   8'h05);

        // Carry chain, borrow, taken JC; loaded while halted
        pg = '{8'h1F, 8'h2F, 8'h51, 8'h80, 8'hB0, 8'h10, 8'h31, 8'h80,
               8'h21, 8'hBC, 8'hF0, 8'hF0, 8'h41, 8'h80, 8'hF0, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_prog(pg, 16, 1);
        run_prog(MAXC, 0, 1, h);
        check_eq("arith_out", out_data, 8'h1E);

        // Countdown loop
        pg[0] = 8'h13; pg[1] = 8'h31; pg[2] = 8'hA4; pg[3] = 8'h91; pg[4] = 8'hF0;
        load_prog(pg, 5, 0);
        run_prog(MAXC, 0, 1, h);
        check_eq("loop_pc", 8'(pc_dbg), 8'd5);

        // IN / OUT
        in_data = 8'hA5;
        pg[0] = 8'h70; pg[1] = 8'h80; pg[2] = 8'hF0;
        load_prog(pg, 3, 0);
        run_prog(20, 0, 1, h);
        check_eq("io_out", out_data, 8'hA5);

        // Byte offered with start must not land at mem[2]
        pg[0] = 8'h1A; pg[1] = 8'h80;
        load_prog(pg, 2, 0);
        run_prog(20, 1, 0, h);
        check_eq("startload_halted", 8'(halted), 8'd1);

        // Seventeen bytes: the last one overwrites address 0
        for (int i = 0; i < 17; i++) pg[i] = 8'($urandom);
        pg[0] = 8'hF0; pg[1] = 8'h80; pg[2] = 8'hF0; pg[16] = 8'h19;
        load_prog(pg, 17, 1);
        run_prog(20, 0, 0, h);
        check_eq("wrap_out", out_data, 8'h09);

        // rst in an EXEC cycle, then a clean rerun of the retained program
        pg = '{8'h1F, 8'h2F, 8'h51, 8'h80, 8'hB0, 8'h10, 8'h31, 8'h80,
               8'h21, 8'hBC, 8'hF0, 8'hF0, 8'h41, 8'h80, 8'hF0, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_prog(pg, 16, 0);
        run_prog(8, 0, 0, h);
        do_reset;
        run_prog(MAXC, 0, 1, h);

        for (int it = 0; it < 40; it++) begin
            if (!h || $urandom_range(0, 3) == 0) do_reset;
            for (int i = 0; i < 16; i++) pg[i] = 8'($urandom);
            in_data = 8'($urandom);
            load_prog(pg, 16, 1);
            run_prog($urandom_range(10, MAXC), 0, 1, h);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
